uart_rx_ctrl: RTL and testbench

UART receive controller that sequences the oversampled bit-sampling path of the microprocessor's serial port. Inputs are a 16× baud sample tick and the raw serial line. The block detects and qualifies the start bit, counts samples to each bit centre, and shifts in LSB-first data. It then checks the stop bit and presents each completed character to the CPU-side register interface through a valid/ready holding register with sticky framing and overrun flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive path.
//   rx_state_t        receiver sequencing states
//   UART_OVERSAMPLE   default sample ticks per bit
//   UART_DATA_BITS    default data bits per frame
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk        destination clock
//   rst_n      asynchronous active-low reset, both flops load RESET_VAL
//   d_i        asynchronous input
//   q_o        synchronized output (two clk of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller with a valid/ready
// holding register and sticky framing/overrun flags.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_in        raw serial line, idle high
//   sample_tick  one-cycle strobe at OVERSAMPLE x baud
//   char_ready   consumer accepts char_out this cycle
//   err_clr      clears frame_err and overrun (a coincident set wins)
//   char_out     received character, LSB = first bit on the line
//   char_valid   char_out holds an unconsumed character
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: a character was dropped because char_out was full
//   busy         receiver is not idle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 sample_tick,
    input  logic                 char_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] char_out,
    output logic                 char_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] char_q, char_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 deliver_s;
    logic                 stop_bad_s;
    logic                 hs_s;
    logic                 ovr_set_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx_in),
        .q_o  (rx_s)
    );

    // Receive sequencing: start qualification, bit-centre counting, shifting, stop check
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        deliver_s  = 1'b0;
        stop_bad_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = CNT_ZERO;
                        // Line back high at mid-start means a glitch, not a frame
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = BIT_ZERO;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        // LSB arrives first, so shift right and insert at the MSB
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            state_d   = STOP;
                            bit_idx_d = BIT_ZERO;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (rx_s) begin
                            deliver_s = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            stop_bad_s = 1'b1;
                            state_d    = WAIT_HI;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT_HI: begin
                // Hold off until a break or bad stop bit releases the line
                if (sample_tick && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = CNT_ZERO;
                bit_idx_d = BIT_ZERO;
            end
        endcase
    end

    // Holding register, handshake and sticky flag next-state
    always_comb begin
        hs_s      = valid_q & char_ready;
        char_d    = char_q;
        valid_d   = valid_q;
        ovr_set_s = 1'b0;
        if (deliver_s) begin
            // A same-cycle handshake frees the register for the new character
            if (!valid_q || hs_s) begin
                char_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (hs_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (stop_bad_s) begin
            ferr_d = 1'b1;
        end else if (err_clr) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end

        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (err_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= BIT_ZERO;
            shreg_q   <= {DATA_BITS{1'b0}};
            char_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit at a fixed
// tick rate; the expected character (or flag) is decided from a frame-level
// model and checked by an independent handshake monitor.
module tb_uart_rx_ctrl;

    localparam int TP = 4;   // clk cycles per sample tick
    localparam int OS = 16;  // ticks per bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       sample_tick = 1'b0;
    logic       char_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] char_out;
    logic       char_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    int         gstep = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .sample_tick(sample_tick),
        .char_ready (char_ready),
        .err_clr    (err_clr),
        .char_out   (char_out),
        .char_valid (char_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must hand over the oldest expected character
    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_char: got %0h expected none", char_out);
            end else begin
                mon_exp = sb.pop_front();
                check("char_out", {24'd0, char_out}, {24'd0, mon_exp});
            end
        end
    end

    // One clock: the edge consuming these inputs has index gstep
    task automatic cyc();
        sample_tick = ((gstep % TP) == 0);
        @(posedge clk);
        #1;
        gstep++;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_ferr});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_char_out", {24'd0, char_out}, 32'd0);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        rx_in = 1'b1;
        char_ready = 1'b0;
        err_clr = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        idle(4 * TP);
    endtask

    // Drive one frame; the stop sample lands 152 ticks after the detecting
    // tick (8 to mid-start, then 16 per data bit and 16 to mid-stop), and the
    // detecting tick is the first one at least two edges after the line fell.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input bit coincide, input int abort_bit);
        int         s0;
        int         det;
        int         dlv;
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        s0 = gstep;
        det = s0 + 2;
        while ((det % TP) != 0) det++;
        dlv = det + 152 * TP;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < OS * TP; k++) begin
                if (b == abort_bit && k == OS * TP / 2) begin
                    do_reset();
                    return;
                end
                rx_in = bits[b];
                if (gstep == dlv) begin
                    if (coincide) char_ready = 1'b1;
                    if (stop_v) begin
                        if (sb.size() > 0 && !char_ready) exp_ovr = 1'b1;
                        else sb.push_back(d);
                    end else begin
                        exp_ferr = 1'b1;
                    end
                end
                cyc();
                if (coincide && gstep == dlv + 1) char_ready = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("init_char_out", {24'd0, char_out}, 32'd0);
        check("init_char_valid", {31'd0, char_valid}, 32'd0);
        check("init_frame_err", {31'd0, frame_err}, 32'd0);
        check("init_overrun", {31'd0, overrun}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // 0x55 with consumer always ready
        char_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(8);
        check("x55_valid_cleared", {31'd0, char_valid}, 32'd0);
        check("x55_drained", sb.size(), 32'd0);

        // Random characters with random gaps
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0, -1);
            idle($urandom_range(1, 40));
        end
        check("rand_drained", sb.size(), 32'd0);
        check_flags("rand");

        // Start glitch: low for 4 ticks only
        rx_in = 1'b0;
        repeat (4 * TP) cyc();
        idle(30 * TP);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, char_valid}, 32'd0);
        check_flags("glitch");

        // Bad stop bit, line held low, then recovery
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        rx_in = 1'b0;
        repeat (2 * OS * TP) cyc();
        check_flags("ferr");
        check("ferr_busy_low_line", {31'd0, busy}, 32'd1);
        check("ferr_valid", {31'd0, char_valid}, 32'd0);
        idle(4 * TP);
        check("ferr_busy_released", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(20);
        check("ferr_next_drained", sb.size(), 32'd0);
        check_flags("ferr_sticky");
        clear_errs();
        check_flags("ferr_clr");

        // Overrun: two characters, nobody reading
        char_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(10);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(10);
        check("ovr_valid", {31'd0, char_valid}, 32'd1);
        check("ovr_char_out", {24'd0, char_out}, 32'h0000_00A5);
        check_flags("ovr");
        clear_errs();
        check_flags("ovr_clr");
        check("ovr_clr_char_out", {24'd0, char_out}, 32'h0000_00A5);
        char_ready = 1'b1;
        idle(4);
        check("ovr_drained", sb.size(), 32'd0);
        check("ovr_valid_cleared", {31'd0, char_valid}, 32'd0);

        // Handshake on the very cycle the next character lands
        char_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(10);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(5);
        check("coin_char_out", {24'd0, char_out}, 32'h0000_003C);
        check("coin_valid", {31'd0, char_valid}, 32'd1);
        check_flags("coin");
        char_ready = 1'b1;
        idle(4);
        check("coin_drained", sb.size(), 32'd0);

        // Reset in the middle of data bit 4 with a character pending
        char_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        idle(10);
        check("pre_rst_valid", {31'd0, char_valid}, 32'd1);
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        char_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(10);
        check("post_rst_drained", sb.size(), 32'd0);
        check("post_rst_valid", {31'd0, char_valid}, 32'd0);
        check_flags("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
